// File: rtl/ddr_perf_wr_gen.sv
// AXI-4 write-traffic initiator for DDR performance measurement.
// Splits a transfer into 4 KB-safe bursts, one outstanding at a time.
module ddr_perf_wr_gen #(
  parameter logic [15:0] ID_VAL = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  start_addr,
  input  logic [31:0]  burst_len,
  input  logic [31:0]  write_val,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  cycle_count,
  output logic [15:0]  awid,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [15:0]  bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] write_val_q, write_val_d;
  logic [31:0] beat_idx_q, beat_idx_d;
  logic [31:0] cycle_q, cycle_d;
  logic [6:0]  beat_cnt_q, beat_cnt_d;
  logic        err_q, err_d;

  logic [6:0]  room;
  logic [6:0]  n;
  logic [31:0] rem_next;
  logic [31:0] beat_data;
  logic        unused_ok;

  assign unused_ok = ^{bid, start_addr[5:0]};

  // Beats left before the next 4 KB page boundary.
  assign room = 7'd64 - {1'b0, cur_addr_q[11:6]};
  assign n = (remaining_q < {25'd0, room}) ? remaining_q[6:0] : room;
  assign rem_next = remaining_q - {25'd0, n};
  assign beat_data = write_val_q + beat_idx_q;

  assign busy    = (state_q == S_AW) || (state_q == S_W) ||
                   (state_q == S_B);
  assign done    = (state_q == S_DONE);
  assign awvalid = (state_q == S_AW);
  assign wvalid  = (state_q == S_W);
  assign bready  = (state_q == S_B);
  assign err         = err_q;
  assign cycle_count = cycle_q;
  assign awid    = ID_VAL;
  assign awsize  = 3'd6;
  assign wstrb   = '1;
  assign awaddr  = awvalid ? {32'd0, cur_addr_q} : 64'd0;
  assign awlen   = awvalid ? {1'b0, n - 7'd1} : 8'd0;
  assign wdata   = wvalid ? {16{beat_data}} : 512'd0;
  assign wlast   = wvalid && (beat_cnt_q == n - 7'd1);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    write_val_d = write_val_q;
    beat_idx_d  = beat_idx_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    cycle_d     = cycle_q;
    if (busy && cycle_q != 32'hFFFF_FFFF) begin
      cycle_d = cycle_q + 32'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = {start_addr[31:6], 6'b0};
          remaining_d = burst_len;
          write_val_d = write_val;
          beat_idx_d  = 32'd0;
          err_d       = 1'b0;
          cycle_d     = 32'd0;
          state_d     = (burst_len == 32'd0) ? S_DONE : S_AW;
        end
      end
      S_AW: begin
        beat_cnt_d = 7'd0;
        if (awready) state_d = S_W;
      end
      S_W: begin
        if (wready) begin
          beat_idx_d = beat_idx_q + 32'd1;
          beat_cnt_d = beat_cnt_q + 7'd1;
          if (wlast) state_d = S_B;
        end
      end
      S_B: begin
        if (bvalid) begin
          err_d       = err_q | (bresp != 2'b00);
          remaining_d = rem_next;
          cur_addr_d  = cur_addr_q + {19'd0, n, 6'd0};
          state_d     = (rem_next == 32'd0) ? S_DONE : S_AW;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= 32'd0;
      remaining_q <= 32'd0;
      write_val_q <= 32'd0;
      beat_idx_q  <= 32'd0;
      beat_cnt_q  <= 7'd0;
      err_q       <= 1'b0;
      cycle_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      write_val_q <= write_val_d;
      beat_idx_q  <= beat_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      cycle_q     <= cycle_d;
    end
  end

endmodule

// File: tb/tb_ddr_perf_wr_gen.sv
// Directed bench for ddr_perf_wr_gen with an AXI slave responder
// and AW/W scoreboards filled from a reference burst model.
module tb_ddr_perf_wr_gen;

  localparam logic [15:0] ID = 16'h00A5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  start_addr = '0;
  logic [31:0]  burst_len = '0;
  logic [31:0]  write_val = '0;
  logic         busy, done, err;
  logic [31:0]  cycle_count;
  logic [15:0]  awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b0;
  logic [15:0]  bid = '0;
  logic [1:0]   bresp = '0;
  logic         bvalid = 1'b0;
  logic         bready;

  ddr_perf_wr_gen #(.ID_VAL(ID)) dut (
    .clk(clk), .rst(rst), .start(start),
    .start_addr(start_addr), .burst_len(burst_len),
    .write_val(write_val), .busy(busy), .done(done),
    .err(err), .cycle_count(cycle_count), .awid(awid),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;
  typedef struct {
    logic [31:0] d;
    logic        last;
  } w_t;

  aw_t aw_q[$];
  w_t  w_q[$];

  int total = 0;
  int fails = 0;
  int aw_stall_n = 0;
  int aw_wait = 0;
  bit wtoggle = 0;
  int err_burst = -1;
  int b_hs, w_hs, wlast_hs, done_cnt, aw_extra, w_extra;
  bit aw_st_prev = 0, w_st_prev = 0;
  logic [63:0]  awaddr_p;
  logic [7:0]   awlen_p;
  logic [511:0] wdata_p;
  logic         wlast_p;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [31:0] a, input logic [31:0] len,
                            input logic [31:0] val, output int nb);
    logic [31:0] addr, rem, idx, n, room;
    addr = {a[31:6], 6'b0};
    rem = len;
    idx = 0;
    nb = 0;
    while (rem != 0) begin
      room = 32'd64 - {26'd0, addr[11:6]};
      n = (rem < room) ? rem : room;
      aw_q.push_back('{addr: addr, len: n[7:0] - 8'd1});
      for (int i = 0; i < int'(n); i++) begin
        w_q.push_back('{d: val + idx, last: (i == int'(n) - 1)});
        idx++;
      end
      addr = addr + n * 32'd64;
      rem = rem - n;
      nb++;
    end
  endtask

  task automatic tick();
    aw_t ea;
    w_t  ew;
    @(negedge clk);
    if (aw_st_prev) begin
      chk("aw_hold_valid", awvalid, 1'b1);
      chk("aw_hold_addr", awaddr, awaddr_p);
      chk("aw_hold_len", awlen, awlen_p);
    end
    if (w_st_prev) begin
      chk("w_hold_valid", wvalid, 1'b1);
      chk("w_hold_data", wdata, wdata_p);
      chk("w_hold_last", wlast, wlast_p);
    end
    aw_st_prev = (awvalid === 1'b1) && (awready === 1'b0);
    w_st_prev = (wvalid === 1'b1) && (wready === 1'b0);
    awaddr_p = awaddr;
    awlen_p = awlen;
    wdata_p = wdata;
    wlast_p = wlast;
    if (awvalid === 1'b1 && awready === 1'b1) begin
      if (aw_q.size() == 0) aw_extra++;
      else begin
        ea = aw_q.pop_front();
        chk("awaddr", awaddr, {32'd0, ea.addr});
        chk("awlen", awlen, ea.len);
        chk("awsize", awsize, 3'd6);
        chk("awid", awid, ID);
      end
    end
    if (wvalid === 1'b1 && wready === 1'b1) begin
      w_hs++;
      if (wlast === 1'b1) wlast_hs++;
      if (w_q.size() == 0) w_extra++;
      else begin
        ew = w_q.pop_front();
        chk("wdata", wdata, {16{ew.d}});
        chk("wlast", wlast, ew.last);
        chk("wstrb", wstrb, {64{1'b1}});
      end
    end
    if (bready === 1'b1 && bvalid === 1'b1) b_hs++;
    if (done === 1'b1) done_cnt++;
    @(posedge clk);
    #1;
    if (awvalid === 1'b1) begin
      if (aw_wait < aw_stall_n) begin
        awready = 1'b0;
        aw_wait++;
      end else awready = 1'b1;
    end else begin
      awready = 1'b0;
      aw_wait = 0;
    end
    wready = wtoggle ? ~wready : 1'b1;
    bvalid = (bready === 1'b1);
    bresp = (bvalid && b_hs == err_burst) ? 2'b10 : 2'b00;
  endtask

  task automatic run_xfer(input logic [31:0] a, input logic [31:0] len,
                          input logic [31:0] val, input int eb,
                          input logic exp_err, input int exp_cyc,
                          input bit poke);
    int nb;
    bit poked;
    poked = 0;
    push_model(a, len, val, nb);
    err_burst = eb;
    b_hs = 0; w_hs = 0; wlast_hs = 0;
    done_cnt = 0; aw_extra = 0; w_extra = 0;
    start_addr = a;
    burst_len = len;
    write_val = val;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clr", err, 1'b0);
    chk("cyc_clr", cycle_count, 32'd0);
    if (len == 0) begin
      chk("len0_done", done, 1'b1);
      chk("len0_awvalid", awvalid, 1'b0);
      chk("len0_busy", busy, 1'b0);
    end else begin
      chk("k1_awvalid", awvalid, 1'b1);
      chk("k1_busy", busy, 1'b1);
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      if (poke && !poked && wvalid === 1'b1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        poked = 1;
      end else tick();
    end
    chk("done_seen", done_cnt, 1);
    tick();
    chk("done_once", done_cnt, 1);
    chk("aw_left", aw_q.size(), 0);
    chk("w_left", w_q.size(), 0);
    chk("aw_extra", aw_extra, 0);
    chk("w_extra", w_extra, 0);
    chk("w_beats", w_hs, int'(len));
    chk("wlast_cnt", wlast_hs, nb);
    chk("b_cnt", b_hs, nb);
    chk("err_final", err, exp_err);
    if (exp_cyc >= 0) chk("cycle_count", cycle_count, exp_cyc);
    aw_q.delete();
    w_q.delete();
  endtask

  task automatic check_reset(input string p);
    chk({p, "_busy"}, busy, 1'b0);
    chk({p, "_done"}, done, 1'b0);
    chk({p, "_err"}, err, 1'b0);
    chk({p, "_cyc"}, cycle_count, 32'd0);
    chk({p, "_awvalid"}, awvalid, 1'b0);
    chk({p, "_wvalid"}, wvalid, 1'b0);
    chk({p, "_wlast"}, wlast, 1'b0);
    chk({p, "_bready"}, bready, 1'b0);
    chk({p, "_awaddr"}, awaddr, 64'd0);
    chk({p, "_awlen"}, awlen, 8'd0);
    chk({p, "_wdata"}, wdata, 512'd0);
    chk({p, "_awsize"}, awsize, 3'd6);
    chk({p, "_awid"}, awid, ID);
    chk({p, "_wstrb"}, wstrb, {64{1'b1}});
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      start_addr = $urandom;
      burst_len = $urandom;
      write_val = $urandom;
      awready = 1'($urandom);
      wready = 1'($urandom);
      bvalid = 1'($urandom);
      bresp = 2'($urandom);
      @(posedge clk);
      #1;
    end
    check_reset("rst");
    rst = 1'b0;
    start = 1'b0;
    awready = 1'b0;
    wready = 1'b1;
    bvalid = 1'b0;
    bresp = 2'b00;

    run_xfer(32'h0000_1000, 32'd4, 32'hA5A5_0000, -1, 1'b0, 6, 0);
    run_xfer(32'h0000_0FC0, 32'd3, 32'h1111_0000, -1, 1'b0, 7, 0);
    run_xfer(32'h0000_0000, 32'd130, 32'h0BAD_0000, -1, 1'b0, 136, 0);

    aw_stall_n = 5;
    wtoggle = 1;
    run_xfer(32'h0000_0000, 32'd70, 32'hC0DE_0000, 0, 1'b1, -1, 0);
    aw_stall_n = 0;
    wtoggle = 0;
    run_xfer(32'h0000_0047, 32'd2, 32'h0000_1234, -1, 1'b0, 4, 0);

    run_xfer(32'h0000_2000, 32'd0, 32'h5555_5555, -1, 1'b0, 0, 0);
    run_xfer(32'h0000_2000, 32'd8, 32'h7777_0000, -1, 1'b0, 10, 1);
    run_xfer(32'hFFFF_F000, 32'd128, 32'hFFFF_FFF0, -1, 1'b0, 132, 0);

    push_model(32'h0000_3000, 32'd8, 32'h9999_0000, nb);
    b_hs = 0; w_hs = 0; wlast_hs = 0; done_cnt = 0;
    start_addr = 32'h0000_3000;
    burst_len = 32'd8;
    write_val = 32'h9999_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && wvalid !== 1'b1; i++) tick();
    tick();
    chk("midw_wvalid", wvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midw");
    rst = 1'b0;
    aw_q.delete();
    w_q.delete();
    aw_st_prev = 0;
    w_st_prev = 0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
